// File: rtl/srl_fifo_fwft.sv
// Shift-register FIFO with first-word-fall-through head; written data is visible one cycle after enq.
// Enq while full is dropped (sticky overrun) unless a pop happens in the same cycle; o_almost_full gives early backpressure.
module srl_fifo_fwft #(
  parameter int P_WIDTH       = 128,
  parameter int P_DEPTH       = 32,
  parameter int P_AFULL_SLACK = 2,
  localparam int CW           = $clog2(P_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_enq,
  input  logic               i_deq,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almost_full,
  output logic [CW-1:0]      o_count,
  output logic               o_overrun,
  output logic               o_underrun
);

  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(P_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(P_DEPTH - P_AFULL_SLACK);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [CW-1:0]      count_q, count_d;
  logic               ovr_q, ovr_d;
  logic               udr_q, udr_d;
  logic               empty, full, enq_ok, deq_ok;
  logic [AW-1:0]      rd_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    deq_ok  = i_deq & ~empty;
    enq_ok  = i_enq & (~full | deq_ok);
    count_d = count_q;
    ovr_d   = ovr_q;
    udr_d   = udr_q;
    if (i_clear) begin
      count_d = '0;
      ovr_d   = 1'b0;
      udr_d   = 1'b0;
    end else begin
      if (enq_ok && !deq_ok) count_d = count_q + CW'(1);
      if (deq_ok && !enq_ok) count_d = count_q - CW'(1);
      if (i_enq && !enq_ok)  ovr_d   = 1'b1;
      if (i_deq && empty)    udr_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      ovr_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovr_q   <= ovr_d;
      udr_q   <= udr_d;
    end
  end

  // No reset on storage so it can map onto SRL primitives.
  always_ff @(posedge i_clk) begin
    if (enq_ok && !i_clear) begin
      mem_q[0] <= i_data;
      for (int i = 1; i < P_DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign rd_idx        = empty ? '0 : AW'(count_q - CW'(1));
  assign o_data        = mem_q[rd_idx];
  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count_q >= AF_CNT);
  assign o_count       = count_q;
  assign o_overrun     = ovr_q;
  assign o_underrun    = udr_q;

endmodule

// File: tb/tb_srl_fifo_fwft.sv
// Directed checks on an 8-deep FIFO plus a randomised queue-model run on a 5-deep, zero-slack FIFO.
module tb_srl_fifo_fwft;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-deep instance
  logic       rst_n, clear, enq, deq;
  logic [7:0] din, dout;
  logic       empty, full, afull, ovr, udr;
  logic [3:0] count;

  // 5-deep instance
  logic       r_rst_n, r_clear, r_enq, r_deq;
  logic [7:0] r_din, r_dout;
  logic       r_empty, r_full, r_afull, r_ovr, r_udr;
  logic [2:0] r_count;

  int n_assert = 0;
  int n_fail   = 0;

  srl_fifo_fwft #(.P_WIDTH(8), .P_DEPTH(8), .P_AFULL_SLACK(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_data(din), .i_enq(enq), .i_deq(deq),
    .o_data(dout), .o_empty(empty), .o_full(full), .o_almost_full(afull), .o_count(count),
    .o_overrun(ovr), .o_underrun(udr));

  srl_fifo_fwft #(.P_WIDTH(8), .P_DEPTH(5), .P_AFULL_SLACK(0)) dut5 (
    .i_clk(clk), .i_rst_n(r_rst_n), .i_clear(r_clear), .i_data(r_din), .i_enq(r_enq), .i_deq(r_deq),
    .o_data(r_dout), .o_empty(r_empty), .o_full(r_full), .o_almost_full(r_afull), .o_count(r_count),
    .o_overrun(r_ovr), .o_underrun(r_udr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int c, input logic e, input logic f,
                           input logic af, input logic o, input logic u);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_empty"}, 32'(empty), 32'(e));
    chk({tag, "_full"},  32'(full),  32'(f));
    chk({tag, "_afull"}, 32'(afull), 32'(af));
    chk({tag, "_ovr"},   32'(ovr),   32'(o));
    chk({tag, "_udr"},   32'(udr),   32'(u));
  endtask

  logic [7:0] q[$];
  logic       m_ovr, m_udr;

  initial begin
    rst_n = 1'b0; clear = 1'b0; enq = 1'b0; deq = 1'b0; din = '0;
    r_rst_n = 1'b0; r_clear = 1'b0; r_enq = 1'b0; r_deq = 1'b0; r_din = '0;
    #2;
    chk_flags("reset", 0, 1, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1; r_rst_n = 1'b1;
    tick();

    // 1: single word latency
    din = 8'h11; enq = 1'b1;
    tick();
    enq = 1'b0;
    chk("t1_data", 32'(dout), 32'h11);
    chk_flags("t1_after_enq", 1, 0, 0, 0, 0, 0);
    deq = 1'b1;
    tick();
    deq = 1'b0;
    chk_flags("t1_after_deq", 0, 1, 0, 0, 0, 0);

    // 2: fill, overrun, drain in order
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i); enq = 1'b1;
      tick();
      chk("t2_fill_count", 32'(count), 32'(i));
      chk("t2_fill_afull", 32'(afull), 32'(i >= 6));
      chk("t2_fill_full",  32'(full),  32'(i == 8));
    end
    din = 8'h99;
    tick();
    enq = 1'b0;
    chk_flags("t2_overrun", 8, 0, 1, 1, 1, 0);
    chk("t2_head_kept", 32'(dout), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain_data", 32'(dout), 32'(i));
      deq = 1'b1;
      tick();
    end
    deq = 1'b0;
    chk_flags("t2_drained", 0, 1, 0, 0, 1, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_flags("t2_clear", 0, 1, 0, 0, 0, 0);

    // 3: full-rate pass-through at full
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i); enq = 1'b1;
      tick();
    end
    din = 8'hAA; deq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_pass_data", 32'(dout), 32'(i));
      tick();
      chk("t3_pass_count", 32'(count), 32'd8);
    end
    enq = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_aa_data", 32'(dout), 32'hAA);
      tick();
    end
    deq = 1'b0;
    chk_flags("t3_end", 0, 1, 0, 0, 0, 0);

    // 4: enq+deq on empty
    din = 8'h55; enq = 1'b1; deq = 1'b1;
    tick();
    enq = 1'b0; deq = 1'b0;
    chk_flags("t4", 1, 0, 0, 0, 0, 1);
    chk("t4_data", 32'(dout), 32'h55);

    // 5: clear beats enq/deq, count 5 with overrun set
    enq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h60 + i);
      tick();
    end
    enq = 1'b0; deq = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    deq = 1'b0;
    chk_flags("t5_pre", 5, 0, 0, 0, 1, 1);
    clear = 1'b1; enq = 1'b1; deq = 1'b1;
    tick();
    clear = 1'b0; enq = 1'b0; deq = 1'b0;
    chk_flags("t5_post", 0, 1, 0, 0, 0, 0);

    // 6: random traffic against a queue model, async reset mid-stream
    m_ovr = 1'b0; m_udr = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) begin
        r_rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(r_count), 32'd0);
        chk("t6_rst_empty", 32'(r_empty), 32'd1);
        chk("t6_rst_full",  32'(r_full),  32'd0);
        chk("t6_rst_ovr",   32'(r_ovr),   32'd0);
        chk("t6_rst_udr",   32'(r_udr),   32'd0);
        q.delete(); m_ovr = 1'b0; m_udr = 1'b0;
        r_enq = 1'b0; r_deq = 1'b0;
        tick();
        r_rst_n = 1'b1;
        tick();
      end
      begin
        logic e, d, d_ok, e_ok;
        logic [7:0] v;
        e = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        v = 8'($urandom);
        r_enq = e; r_deq = d; r_din = v;
        if (q.size() > 0) chk("t6_head", 32'(r_dout), 32'(q[0]));
        d_ok = d && (q.size() > 0);
        e_ok = e && ((q.size() < 5) || d_ok);
        if (d && !d_ok) m_udr = 1'b1;
        if (e && !e_ok) m_ovr = 1'b1;
        tick();
        if (d_ok) void'(q.pop_front());
        if (e_ok) q.push_back(v);
        chk("t6_count", 32'(r_count), 32'(q.size()));
        chk("t6_empty", 32'(r_empty), 32'(q.size() == 0));
        chk("t6_afull", 32'(r_afull), 32'(q.size() == 5));
        chk("t6_ovr",   32'(r_ovr),   32'(m_ovr));
        chk("t6_udr",   32'(r_udr),   32'(m_udr));
      end
    end
    r_enq = 1'b0; r_deq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
